// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the bit-scan serializer slice.
package bit_scan_pkg;

   typedef enum logic {IDLE, SCAN} bit_scan_state_t;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/leading_one_trailing_one.sv
// Combinational finder: highest and lowest set-bit positions of a vector.
// Both indices read 0 when the vector is all zeroes.
module leading_one_trailing_one
   import bit_scan_pkg::*;
#(
   parameter int  N  = 8,
   localparam int IW = idx_width(N)
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] leadingone,
   output logic [IW-1:0] trailingone,
   output logic          all_zeroes
);

   always_comb begin
      leadingone  = '0;
      trailingone = '0;
      // Ascending sweep leaves the highest hit, descending sweep the lowest.
      for (int i = 0; i < N; i++) begin
         if (vec[i]) leadingone = IW'(i);
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) trailingone = IW'(i);
      end
   end

   assign all_zeroes = ~|vec;

endmodule

// File: rtl/bit_scan_serializer.sv
// Drains a captured bit vector as a stream of set-bit indices, one per beat.
// Define BIT_SCAN_MSB_FIRST_EN to emit highest index first instead of lowest.
module bit_scan_serializer
   import bit_scan_pkg::*;
#(
   parameter int  N  = 8,
   localparam int IW = idx_width(N)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_vec_valid,
   output logic          o_vec_ready,
   input  logic [N-1:0]  i_vec,
   output logic          o_idx_valid,
   input  logic          i_idx_ready,
   output logic [IW-1:0] o_idx,
   output logic          o_last,
   output logic          o_zero_done,
   output logic          o_busy
);

   bit_scan_state_t state, state_nxt;
   logic [N-1:0]    pending, pending_nxt;
   logic            zero_done_nxt;
   logic [IW-1:0]   lead_idx, trail_idx, sel_idx;
   logic            all_zero;
   logic            single_bit;

   leading_one_trailing_one #(.N(N)) u_finder (
      .vec         (pending),
      .leadingone  (lead_idx),
      .trailingone (trail_idx),
      .all_zeroes  (all_zero)
   );

`ifdef BIT_SCAN_MSB_FIRST_EN
   assign sel_idx = lead_idx;
`else
   assign sel_idx = trail_idx;
`endif

   // Exactly one bit left means the current beat closes the vector.
   assign single_bit  = ((pending & (pending - N'(1))) == '0);

   assign o_busy      = (state == SCAN);
   assign o_idx_valid = (state == SCAN);
   assign o_vec_ready = (state == IDLE);
   assign o_idx       = sel_idx;
   assign o_last      = (state == SCAN) && single_bit;

   always_comb begin
      state_nxt     = state;
      pending_nxt   = pending;
      zero_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (i_vec_valid) begin
               if (|i_vec) begin
                  pending_nxt = i_vec;
                  state_nxt   = SCAN;
               end else begin
                  zero_done_nxt = 1'b1;
               end
            end
         end
         SCAN: begin
            if (i_idx_ready) begin
               pending_nxt = pending & ~(N'(1) << sel_idx);
               if (single_bit) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IDLE;
         pending     <= '0;
         o_zero_done <= 1'b0;
      end else begin
         state       <= state_nxt;
         pending     <= pending_nxt;
         o_zero_done <= zero_done_nxt;
      end
   end

   // A held vector is never empty, and the two finder outputs must be ordered.
   a_pending_live: assert property (@(posedge i_clk) disable iff (i_rst)
      (state == SCAN) |-> (!all_zero && (lead_idx >= trail_idx)));

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Scoreboard bench for bit_scan_serializer; honours BIT_SCAN_MSB_FIRST_EN.
module tb_bit_scan_serializer;

   localparam int N  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_vec_valid = 1'b0;
   logic          i_idx_ready = 1'b0;
   logic [N-1:0]  i_vec = '0;
   logic          o_vec_ready, o_idx_valid, o_last, o_zero_done, o_busy;
   logic [IW-1:0] o_idx;

   int total = 0;
   int bad   = 0;

   logic [IW:0]   exp_q[$];
   logic [IW:0]   exp_e;
   bit            prev_stall = 1'b0;
   logic [IW-1:0] prev_idx;
   logic          prev_last;

   bit_scan_serializer #(.N(N)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_vec_valid (i_vec_valid),
      .o_vec_ready (o_vec_ready),
      .i_vec       (i_vec),
      .o_idx_valid (o_idx_valid),
      .i_idx_ready (i_idx_ready),
      .o_idx       (o_idx),
      .o_last      (o_last),
      .o_zero_done (o_zero_done),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exhausted");
      $fatal(1, "watchdog");
   end

   // Expected beats of one vector, in emission order, each {idx, last}.
   function automatic void push_vec(input logic [N-1:0] v);
      int cnt;
      cnt = $countones(v);
`ifdef BIT_SCAN_MSB_FIRST_EN
      for (int i = N - 1; i >= 0; i--) begin
`else
      for (int i = 0; i < N; i++) begin
`endif
         if (v[i]) begin
            exp_q.push_back({IW'(i), (cnt == 1)});
            cnt--;
         end
      end
   endfunction

   // Beat checker: pops the scoreboard on every handshake, checks stall hold.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            total++;
            if (o_idx_valid !== 1'b1 || o_idx !== prev_idx || o_last !== prev_last) begin
               bad++;
               $display("FAIL stall_hold: got valid=%0b idx=%0d last=%0b, need valid=1 idx=%0d last=%0b",
                        o_idx_valid, o_idx, o_last, prev_idx, prev_last);
            end
         end
         if (o_idx_valid === 1'b1 && i_idx_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL beat_extra: got idx=%0d last=%0b, need no beat", o_idx, o_last);
            end else begin
               exp_e = exp_q.pop_front();
               if ({o_idx, o_last} !== exp_e) begin
                  bad++;
                  $display("FAIL beat: got idx=%0d last=%0b, need idx=%0d last=%0b",
                           o_idx, o_last, exp_e[IW:1], exp_e[0]);
               end
            end
         end
         prev_stall = (o_idx_valid === 1'b1) && (i_idx_ready !== 1'b1);
         prev_idx   = o_idx;
         prev_last  = o_last;
      end
   end

   task automatic wait_ready();
      int w;
      w = 0;
      while (o_vec_ready !== 1'b1 && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      total++;
      if (o_vec_ready !== 1'b1) begin
         bad++;
         $display("FAIL vec_ready_timeout: got ready=%0b, need 1", o_vec_ready);
      end
   endtask

   // Offers one vector for a single cycle; i_vec is scrambled after the edge.
   task automatic send(input logic [N-1:0] v);
      wait_ready();
      i_vec_valid = 1'b1;
      i_vec       = v;
      if (v != '0) push_vec(v);
      @(posedge clk); #1;
      i_vec_valid = 1'b0;
      i_vec       = N'($urandom);
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      #1;
      total++;
      if ({o_vec_ready, o_idx_valid, o_idx, o_last, o_zero_done, o_busy} !== {1'b1, 1'b0, {IW{1'b0}}, 3'b000}) begin
         bad++;
         $display("FAIL reset_async: got rdy=%0b vld=%0b idx=%0d last=%0b zd=%0b busy=%0b, need 1 0 0 0 0 0",
                  o_vec_ready, o_idx_valid, o_idx, o_last, o_zero_done, o_busy);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      total++;
      if (o_vec_ready !== 1'b1 || o_idx_valid !== 1'b0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: got rdy=%0b vld=%0b busy=%0b, need 1 0 0", o_vec_ready, o_idx_valid, o_busy);
      end
   endtask

   task automatic test_basic();
      i_idx_ready = 1'b1;
      send(8'b1010_0110);
      total++;
`ifdef BIT_SCAN_MSB_FIRST_EN
      if (o_idx_valid !== 1'b1 || o_idx !== 3'd7) begin
`else
      if (o_idx_valid !== 1'b1 || o_idx !== 3'd1) begin
`endif
         bad++;
         $display("FAIL first_beat_latency: got vld=%0b idx=%0d, need vld=1 first index", o_idx_valid, o_idx);
      end
      repeat (4) begin
         @(posedge clk); #1;
      end
      total++;
      if (o_vec_ready !== 1'b1 || o_busy !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL basic_drain: got rdy=%0b busy=%0b left=%0d, need 1 0 0", o_vec_ready, o_busy, exp_q.size());
      end
   endtask

   task automatic test_stall();
      bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      send(8'b1010_0110);
      for (int i = 0; i < 7; i++) begin
         i_idx_ready = pat[i];
         @(posedge clk); #1;
      end
      total++;
      if (o_vec_ready !== 1'b1 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL stall_drain: got rdy=%0b left=%0d, need 1 0", o_vec_ready, exp_q.size());
      end
      i_idx_ready = 1'b1;
   endtask

   task automatic test_zero();
      send(8'h00);
      total++;
      if (o_zero_done !== 1'b1 || o_idx_valid !== 1'b0 || o_vec_ready !== 1'b1) begin
         bad++;
         $display("FAIL zero_pulse: got zd=%0b vld=%0b rdy=%0b, need 1 0 1", o_zero_done, o_idx_valid, o_vec_ready);
      end
      @(posedge clk); #1;
      total++;
      if (o_zero_done !== 1'b0 || o_idx_valid !== 1'b0) begin
         bad++;
         $display("FAIL zero_single: got zd=%0b vld=%0b, need 0 0", o_zero_done, o_idx_valid);
      end
   endtask

   task automatic test_back_to_back();
      wait_ready();
      i_idx_ready = 1'b1;
      i_vec_valid = 1'b1;
      i_vec       = 8'h80;
      push_vec(8'h80);
      @(posedge clk); #1;
      i_vec = 8'h01;
      total++;
      if (o_vec_ready !== 1'b0 || o_busy !== 1'b1 || o_last !== 1'b1) begin
         bad++;
         $display("FAIL b2b_busy: got rdy=%0b busy=%0b last=%0b, need 0 1 1", o_vec_ready, o_busy, o_last);
      end
      @(posedge clk); #1;
      total++;
      if (o_vec_ready !== 1'b1 || o_idx_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle_gap: got rdy=%0b vld=%0b, need 1 0", o_vec_ready, o_idx_valid);
      end
      push_vec(8'h01);
      @(posedge clk); #1;
      i_vec_valid = 1'b0;
      total++;
      if (o_idx_valid !== 1'b1 || o_idx !== 3'd0 || o_last !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second: got vld=%0b idx=%0d last=%0b, need 1 0 1", o_idx_valid, o_idx, o_last);
      end
      @(posedge clk); #1;
      total++;
      if (o_vec_ready !== 1'b1 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL b2b_drain: got rdy=%0b left=%0d, need 1 0", o_vec_ready, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      i_idx_ready = 1'b1;
      send(8'hFF);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      total++;
      if ({o_vec_ready, o_idx_valid, o_idx, o_last, o_zero_done, o_busy} !== {1'b1, 1'b0, {IW{1'b0}}, 3'b000}) begin
         bad++;
         $display("FAIL reset_mid: got rdy=%0b vld=%0b idx=%0d last=%0b zd=%0b busy=%0b, need 1 0 0 0 0 0",
                  o_vec_ready, o_idx_valid, o_idx, o_last, o_zero_done, o_busy);
      end
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         total++;
         if (o_vec_ready !== 1'b1 || o_idx_valid !== 1'b0 || o_idx !== '0) begin
            bad++;
            $display("FAIL reset_no_stale: got rdy=%0b vld=%0b idx=%0d, need 1 0 0", o_vec_ready, o_idx_valid, o_idx);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random();
      logic [N-1:0] v;
      int w;
      for (int n = 0; n < 20; n++) begin
         v = N'($urandom);
         if (n == 0) v = 8'h81;
         send(v);
         w = 0;
         while ((exp_q.size() != 0 || o_vec_ready !== 1'b1) && w < 200) begin
            i_idx_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            w++;
         end
         total++;
         if (exp_q.size() != 0 || o_vec_ready !== 1'b1) begin
            bad++;
            $display("FAIL random_drain vec=%h: got left=%0d rdy=%0b, need 0 1", v, exp_q.size(), o_vec_ready);
         end
      end
      i_idx_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bit_scan_serializer.md
Name: bit_scan_serializer

Overview:
- Sequential consumer of a one-hot/multi-hot bit vector; emits the index of every set bit, one per cycle, lowest index first, over a valid/ready stream.
- Sits downstream of the combinational leading/trailing-one finder. Feeds per-index work (interrupt dispatch, free-slot release, per-channel service) to a single-issue consumer.
- Holds one vector at a time. A new vector is accepted only after the previous one is fully drained.

Parameters:
- N, 8, width of the scanned vector; N >= 2.
- IW, $clog2(N), index width (derived, not overridden).

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_vec_valid  input  1  vector offered.
- o_vec_ready  output  1  block can accept a vector.
- i_vec  input  N  vector to scan.
- o_idx_valid  output  1  o_idx holds a pending set-bit index.
- i_idx_ready  input  1  downstream accepts o_idx.
- o_idx  output  IW  index of current bit.
- o_last  output  1  current index is the final set bit of the vector.
- o_zero_done  output  1  one-cycle pulse: an all-zero vector was accepted.
- o_busy  output  1  vector held (state SCAN).

Behaviour:
- Reset values (async, immediate): state=IDLE, pending=0, o_idx_valid=0, o_idx=0, o_last=0, o_zero_done=0, o_busy=0, o_vec_ready=1.
- States:
  - IDLE: o_vec_ready=1, o_idx_valid=0. On i_vec_valid: if i_vec!=0, pending<=i_vec, go to SCAN; if i_vec==0, stay IDLE and pulse o_zero_done next cycle.
  - SCAN: o_vec_ready=0, o_busy=1, o_idx_valid=1.
- Outputs in SCAN:
  - o_idx = trailing-one position of pending, derived combinationally from the registered pending.
  - o_last=1 when popcount(pending)==1.
- Handshake in SCAN:
  - On o_idx_valid && i_idx_ready, clear bit o_idx in pending.
  - If o_last, go to IDLE (pending becomes 0).
  - If not accepted, o_idx, o_last and pending hold stable; o_idx_valid never drops without acceptance.
- Latency: vector accepted at edge k gives the first o_idx valid after edge k, i.e. in cycle k+1.
- Throughput: one index per cycle while i_idx_ready=1. A vector with M set bits occupies SCAN for M cycles minimum. The next vector is accepted one cycle after the last beat (IDLE cycle). There is no same-cycle refill.
- i_vec is sampled only on the accepting edge; later changes are ignored.
- Index N-1 and index 0 are handled identically; there is no wrap-around.
- Reset asserted mid-SCAN: the pending vector is discarded, outputs return to reset values asynchronously, no o_last is emitted.
- o_zero_done is a single-cycle pulse and does not assert o_idx_valid.

Optional Feature:
- Macro BIT_SCAN_MSB_FIRST_EN.
- Defined: o_idx is the leading-one (highest set) position, so indices are emitted in descending order; o_last still marks the final remaining bit.
- Undefined: lowest-first order as above.
- Handshake, latency and reset are identical in both builds.

Decomposition:
- Package bit_scan_pkg holds:
  - typedef enum logic {IDLE, SCAN} bit_scan_state_t;
  - a function computing index width from N.
- Sub-module: the existing leading_one_trailing_one finder, instantiated once on pending.
  - Use its trailingone output by default, leadingone under BIT_SCAN_MSB_FIRST_EN.
  - Use its all_zeroes output as an assertion cross-check that pending!=0 in SCAN.
- popcount==1 test is implemented as pending & (pending-1) == 0.

Test Plan:
- Reset, then i_vec=8'b1010_0110 with i_idx_ready=1 -> o_idx 1,2,5,7 on four consecutive cycles, o_last only on idx 7, o_vec_ready=1 the following cycle.
- Same vector with i_idx_ready toggling 1,0,0,1,0,1,1 -> o_idx held stable during stalls, same sequence 1,2,5,7, no drops or duplicates.
- i_vec=8'h00 -> o_zero_done pulses one cycle, o_idx_valid stays 0, o_vec_ready stays 1.
- i_vec=8'h80 then 8'h01 back-to-back offered -> idx 7 with o_last, one IDLE cycle, then idx 0 with o_last; the second vector is not accepted while busy.
- i_rst asserted after the first beat of 8'hFF -> all outputs at reset values immediately; after release, o_vec_ready=1 and no stale index appears.
- With BIT_SCAN_MSB_FIRST_EN, i_vec=8'b1010_0110 -> o_idx 7,5,2,1, o_last on idx 1.
